// File: rtl/sc_lanebank_pkg.sv
// Shared encodings and helpers for the multi-lane traffic register bank.
// FSM states, rotation directions and the lane bit-offset helper.
package sc_lanebank_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_HOLD    = 2'b10
  } lane_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // LSB position of a lane inside a lane-concatenated bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sc_lane_ticker.sv
// Per-lane period counter: raises shift for one cycle every 'period' running cycles.
// shift is combinational from the count; the count itself is registered.
module sc_lane_ticker #(
  parameter int PERIOD_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    zero,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    shift
);

  logic [PERIOD_WIDTH-1:0] count;
  logic                    due;

  // >= rather than == so a period lowered below the current count fires next cycle.
  assign due   = (period != '0) && (count >= period - PERIOD_WIDTH'(1));
  assign shift = run && !zero && due;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (zero || (run && ((period == '0) || due))) begin
      count <= '0;
    end else if (run) begin
      count <= count + PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_reg_lane_bank.sv
// LANES rotating lane patterns with init/transition/load priority mux and run/hold/stop FSM.
// All outputs registered (one-cycle latency). SC_REGLANEBANK_NOWRAP_EN selects logical shifts plus empty flags.
module sc_reg_lane_bank
  import sc_lanebank_pkg::*;
#(
  parameter int                          DATAWIDTH    = 8,
  parameter int                          LANES        = 4,
  parameter int                          LANE_IDX_W   = 2,
  parameter int                          PERIOD_WIDTH = 8,
  parameter int                          HOLD_CYCLES  = 16,
  parameter logic [LANES*DATAWIDTH-1:0]  INIT_PATTERN = '0
) (
  input  logic                            SC_RegLANEBANK_CLOCK_50,
  input  logic                            SC_RegLANEBANK_RESET_InLow,
  input  logic                            SC_RegLANEBANK_clear_InLow,
  input  logic                            SC_RegLANEBANK_collision_InLow,
  input  logic                            SC_RegLANEBANK_nest_reached_InLow,
  input  logic                            SC_RegLANEBANK_frog_reset_InLow,
  input  logic                            SC_RegLANEBANK_enable_In,
  input  logic                            SC_RegLANEBANK_transition_In,
  input  logic [LANES*DATAWIDTH-1:0]      SC_RegLANEBANK_transitionDATA_InBUS,
  input  logic                            SC_RegLANEBANK_load_InLow,
  input  logic [LANE_IDX_W-1:0]           SC_RegLANEBANK_loadlane_In,
  input  logic [DATAWIDTH-1:0]            SC_RegLANEBANK_loaddata_InBUS,
  input  logic [LANES-1:0]                SC_RegLANEBANK_dir_InBUS,
  input  logic [LANES*PERIOD_WIDTH-1:0]   SC_RegLANEBANK_period_InBUS,
`ifdef SC_REGLANEBANK_NOWRAP_EN
  output logic [LANES-1:0]                SC_RegLANEBANK_empty_OutBUS,
`endif
  output logic [LANES*DATAWIDTH-1:0]      SC_RegLANEBANK_data_OutBUS,
  output logic [LANES-1:0]                SC_RegLANEBANK_shifted_OutBUS,
  output logic [1:0]                      SC_RegLANEBANK_state_OutBUS
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic              clk, rst_n;
  logic              clear_evt, frog_evt, transition, enable, load_ok, run;
  lane_state_t       state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  assign clk        = SC_RegLANEBANK_CLOCK_50;
  assign rst_n      = SC_RegLANEBANK_RESET_InLow;
  assign clear_evt  = ~SC_RegLANEBANK_clear_InLow | ~SC_RegLANEBANK_collision_InLow |
                      ~SC_RegLANEBANK_nest_reached_InLow;
  assign frog_evt   = ~SC_RegLANEBANK_frog_reset_InLow;
  assign transition = SC_RegLANEBANK_transition_In;
  assign enable     = SC_RegLANEBANK_enable_In;
  assign load_ok    = ~SC_RegLANEBANK_load_InLow && (32'(SC_RegLANEBANK_loadlane_In) < LANES);
  assign run        = (state == ST_RUNNING);

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (clear_evt) begin
      state_nxt = ST_HOLD;
      hold_nxt  = HOLD_W'(HOLD_CYCLES - 1);
    end else if (frog_evt) begin
      state_nxt = enable ? ST_RUNNING : ST_STOPPED;
    end else begin
      case (state)
        ST_STOPPED: if (enable) state_nxt = ST_RUNNING;
        ST_RUNNING: if (!enable) state_nxt = ST_STOPPED;
        ST_HOLD: begin
          if (hold_cnt == '0) state_nxt = enable ? ST_RUNNING : ST_STOPPED;
          else                hold_nxt  = hold_cnt - HOLD_W'(1);
        end
        default: state_nxt = ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_STOPPED;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign SC_RegLANEBANK_state_OutBUS = state;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, DATAWIDTH);

    logic [DATAWIDTH-1:0] lane_q, moved;
    logic                 load_hit, zero, shift, shifted_q;

    assign load_hit = load_ok && (32'(SC_RegLANEBANK_loadlane_In) == i);
    assign zero     = clear_evt | frog_evt | transition | load_hit;

`ifdef SC_REGLANEBANK_NOWRAP_EN
    assign moved = (SC_RegLANEBANK_dir_InBUS[i] == DIR_LEFT) ? (lane_q << 1) : (lane_q >> 1);
    assign SC_RegLANEBANK_empty_OutBUS[i] = (lane_q == '0);
`else
    assign moved = (SC_RegLANEBANK_dir_InBUS[i] == DIR_LEFT) ?
                   ((lane_q << 1) | (lane_q >> (DATAWIDTH - 1))) :
                   ((lane_q >> 1) | (lane_q << (DATAWIDTH - 1)));
`endif

    sc_lane_ticker #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_ticker (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (run),
      .zero   (zero),
      .period (SC_RegLANEBANK_period_InBUS[i*PERIOD_WIDTH +: PERIOD_WIDTH]),
      .shift  (shift)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q    <= INIT_PATTERN[LSB +: DATAWIDTH];
        shifted_q <= 1'b0;
      end else begin
        shifted_q <= shift;
        if (clear_evt || frog_evt)  lane_q <= INIT_PATTERN[LSB +: DATAWIDTH];
        else if (transition)        lane_q <= SC_RegLANEBANK_transitionDATA_InBUS[LSB +: DATAWIDTH];
        else if (load_hit)          lane_q <= SC_RegLANEBANK_loaddata_InBUS;
        else if (shift)             lane_q <= moved;
      end
    end

    assign SC_RegLANEBANK_data_OutBUS[LSB +: DATAWIDTH] = lane_q;
    assign SC_RegLANEBANK_shifted_OutBUS[i]             = shifted_q;
  end

endmodule

// File: tb/tb_sc_reg_lane_bank.sv
// Scoreboard bench for sc_reg_lane_bank: a cycle model pushes expected outputs, popped after each edge.
module tb_sc_reg_lane_bank;
  localparam int DW = 8, L = 4, IW = 3, PW = 8, HC = 16;
  localparam logic [L*DW-1:0] INIT = 32'h3C18_0101;

  logic clk = 1'b0;
  logic rst_n, clear_n, coll_n, nest_n, frog_n, enable, transition, load_n;
  logic [L*DW-1:0] tdata;
  logic [IW-1:0]   loadlane;
  logic [DW-1:0]   loaddata;
  logic [L-1:0]    dir;
  logic [L*PW-1:0] period;
  logic [L*DW-1:0] data;
  logic [L-1:0]    shifted;
  logic [1:0]      state;
`ifdef SC_REGLANEBANK_NOWRAP_EN
  logic [L-1:0]    empty;
`endif

  typedef struct packed {
    logic [L*DW-1:0] data;
    logic [L-1:0]    shifted;
    logic [1:0]      state;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0;

  logic [L*DW-1:0] init_v;
  logic [DW-1:0]   m_data[L];
  int              m_cnt[L];
  logic [L-1:0]    m_sh;
  logic [1:0]      m_st;
  int              m_hold;
  logic [L*DW-1:0] snap;

  sc_reg_lane_bank #(
    .DATAWIDTH(DW), .LANES(L), .LANE_IDX_W(IW), .PERIOD_WIDTH(PW),
    .HOLD_CYCLES(HC), .INIT_PATTERN(INIT)
  ) dut (
    .SC_RegLANEBANK_CLOCK_50            (clk),
    .SC_RegLANEBANK_RESET_InLow         (rst_n),
    .SC_RegLANEBANK_clear_InLow         (clear_n),
    .SC_RegLANEBANK_collision_InLow     (coll_n),
    .SC_RegLANEBANK_nest_reached_InLow  (nest_n),
    .SC_RegLANEBANK_frog_reset_InLow    (frog_n),
    .SC_RegLANEBANK_enable_In           (enable),
    .SC_RegLANEBANK_transition_In       (transition),
    .SC_RegLANEBANK_transitionDATA_InBUS(tdata),
    .SC_RegLANEBANK_load_InLow          (load_n),
    .SC_RegLANEBANK_loadlane_In         (loadlane),
    .SC_RegLANEBANK_loaddata_InBUS      (loaddata),
    .SC_RegLANEBANK_dir_InBUS           (dir),
    .SC_RegLANEBANK_period_InBUS        (period),
`ifdef SC_REGLANEBANK_NOWRAP_EN
    .SC_RegLANEBANK_empty_OutBUS        (empty),
`endif
    .SC_RegLANEBANK_data_OutBUS         (data),
    .SC_RegLANEBANK_shifted_OutBUS      (shifted),
    .SC_RegLANEBANK_state_OutBUS        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rot(input logic [DW-1:0] v, input logic d);
`ifdef SC_REGLANEBANK_NOWRAP_EN
    return d ? (v >> 1) : (v << 1);
`else
    return d ? {v[0], v[DW-1:1]} : {v[DW-2:0], v[DW-1]};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_data[i] = init_v[i*DW +: DW];
      m_cnt[i]  = 0;
    end
    m_sh = '0; m_st = 2'b00; m_hold = 0;
  endtask

  task automatic model_step();
    logic clr, frog, hit;
    int p;
    clr  = !clear_n || !coll_n || !nest_n;
    frog = !frog_n;
    for (int i = 0; i < L; i++) begin
      p   = int'(period[i*PW +: PW]);
      hit = !load_n && (int'(loadlane) == i);
      m_sh[i] = 1'b0;
      if (clr || frog) begin m_data[i] = init_v[i*DW +: DW]; m_cnt[i] = 0; end
      else if (transition) begin m_data[i] = tdata[i*DW +: DW]; m_cnt[i] = 0; end
      else if (hit) begin m_data[i] = loaddata; m_cnt[i] = 0; end
      else if (m_st == 2'b01) begin
        if (p == 0) m_cnt[i] = 0;
        else if (m_cnt[i] >= p - 1) begin
          m_data[i] = rot(m_data[i], dir[i]); m_cnt[i] = 0; m_sh[i] = 1'b1;
        end else m_cnt[i]++;
      end
    end
    if (clr) begin m_st = 2'b10; m_hold = HC - 1; end
    else if (frog) m_st = enable ? 2'b01 : 2'b00;
    else if (m_st == 2'b00) begin if (enable) m_st = 2'b01; end
    else if (m_st == 2'b01) begin if (!enable) m_st = 2'b00; end
    else if (m_hold == 0) m_st = enable ? 2'b01 : 2'b00;
    else m_hold--;
  endtask

  task automatic cycle(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      model_step();
      for (int i = 0; i < L; i++) e.data[i*DW +: DW] = m_data[i];
      e.shifted = m_sh;
      e.state   = m_st;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({data, shifted, state} !== e) begin
        errors++;
        $display("FAIL cycle t=%0t: got data=%h sh=%b st=%b, want data=%h sh=%b st=%b",
                 $time, data, shifted, state, e.data, e.shifted, e.state);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_n = 1'b1; coll_n = 1'b1; nest_n = 1'b1; frog_n = 1'b1;
    enable = 1'b0; transition = 1'b0; load_n = 1'b1; tdata = '0; loadlane = '0;
    loaddata = '0; dir = 4'b0010;
    period = {8'd0, 8'd5, 8'd1, 8'd3};
    init_v = INIT;
    model_reset();
    #12;
    checks++;
    if (data !== INIT || state !== 2'b00 || shifted !== 4'b0) begin
      errors++;
      $display("FAIL reset: data=%h st=%b sh=%b, want %h 00 0000", data, state, shifted, INIT);
    end
    rst_n = 1'b1;
    cycle(2);
  endtask

  task automatic test_rotate();
    enable = 1'b1;
    cycle(1);
    cycle(1);
    checks++;
    if (data[15:8] !== 8'h80 || shifted[1] !== 1'b1) begin
      errors++;
      $display("FAIL rotate_right_wrap: lane1=%h sh1=%b, want 80 1", data[15:8], shifted[1]);
    end
    cycle(2);
    checks++;
    if (data[7:0] !== 8'h02 || shifted[0] !== 1'b1) begin
      errors++;
      $display("FAIL rotate_left_c3: lane0=%h sh0=%b, want 02 1", data[7:0], shifted[0]);
    end
    cycle(3);
    checks++;
    if (data[7:0] !== 8'h04 || shifted[0] !== 1'b1) begin
      errors++;
      $display("FAIL rotate_left_c6: lane0=%h sh0=%b, want 04 1", data[7:0], shifted[0]);
    end
    cycle(10);
  endtask

  task automatic test_collision();
    coll_n = 1'b0; cycle(1); coll_n = 1'b1;
    checks++;
    if (data !== INIT || state !== 2'b10) begin
      errors++;
      $display("FAIL collision: data=%h st=%b, want %h 10", data, state, INIT);
    end
    cycle(15);
    checks++;
    if (state !== 2'b10 || shifted !== 4'b0 || data !== INIT) begin
      errors++;
      $display("FAIL hold_end: st=%b sh=%b data=%h, want 10 0000 %h", state, shifted, data, INIT);
    end
    cycle(1);
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL hold_exit: st=%b, want 01", state);
    end
    cycle(4);
    nest_n = 1'b0; cycle(1); nest_n = 1'b1;
    cycle(6);
    clear_n = 1'b0; cycle(1); clear_n = 1'b1;
    cycle(15);
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL hold_reload: st=%b, want 10", state);
    end
    cycle(3);
  endtask

  task automatic test_priority();
    coll_n = 1'b0; transition = 1'b1; tdata = 32'hF0F0_AAAA;
    cycle(1);
    coll_n = 1'b1;
    checks++;
    if (data !== INIT || state !== 2'b10) begin
      errors++;
      $display("FAIL coll_vs_trans: data=%h st=%b, want %h 10", data, state, INIT);
    end
    cycle(1);
    transition = 1'b0;
    checks++;
    if (data !== 32'hF0F0_AAAA || state !== 2'b10) begin
      errors++;
      $display("FAIL trans_in_hold: data=%h st=%b, want f0f0aaaa 10", data, state);
    end
    frog_n = 1'b0; cycle(1); frog_n = 1'b1;
    checks++;
    if (data !== INIT || state !== 2'b01) begin
      errors++;
      $display("FAIL frog_abort: data=%h st=%b, want %h 01", data, state, INIT);
    end
    cycle(5);
  endtask

  task automatic test_load();
    for (int k = 0; k < 10 && m_cnt[2] != 4; k++) cycle(1);
    checks++;
    if (m_cnt[2] != 4) begin
      errors++;
      $display("FAIL load_align: lane2 count=%0d, want 4", m_cnt[2]);
    end
    load_n = 1'b0; loadlane = 3'd2; loaddata = 8'hA5;
    cycle(1);
    load_n = 1'b1;
    checks++;
    if (data[23:16] !== 8'hA5 || shifted[2] !== 1'b0 || shifted[1] !== 1'b1) begin
      errors++;
      $display("FAIL load_lane2: lane2=%h sh=%b, want a5 sh2=0 sh1=1", data[23:16], shifted);
    end
    enable = 1'b0;
    cycle(2);
    snap = data;
    load_n = 1'b0; loadlane = 3'd5; loaddata = 8'h5A;
    cycle(1);
    load_n = 1'b1;
    checks++;
    if (data !== snap) begin
      errors++;
      $display("FAIL load_oob: data=%h, want %h", data, snap);
    end
    enable = 1'b1;
    cycle(2);
  endtask

  task automatic test_period();
    period[7:0] = 8'd0;
    cycle(1);
    snap = data;
    cycle(100);
    checks++;
    if (data[7:0] !== snap[7:0]) begin
      errors++;
      $display("FAIL period_zero: lane0=%h, want %h", data[7:0], snap[7:0]);
    end
    for (int k = 0; k < 10 && m_cnt[2] != 3; k++) cycle(1);
    period[23:16] = 8'd2;
    cycle(1);
    checks++;
    if (shifted[2] !== 1'b1) begin
      errors++;
      $display("FAIL period_lowered: sh2=%b, want 1", shifted[2]);
    end
    cycle(4);
  endtask

  task automatic test_reset_mid_hold();
    coll_n = 1'b0; cycle(1); coll_n = 1'b1;
    cycle(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data !== INIT || state !== 2'b00 || shifted !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: data=%h st=%b sh=%b, want %h 00 0000", data, state, shifted, INIT);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(6);
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_collision();
    test_priority();
    test_load();
    test_period();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
